// File: rtl/gpr_file_ext.sv
// gpr_file_ext: general-purpose register file for the single-cycle MIPS datapath.
// Two combinational read ports, one byte-enabled write port and an overflow-flag
// side write into OF_REG. Register 0 always reads as zero. A synchronous reset
// starts a clear sequencer that zeroes one entry per cycle; `ready` rises once
// every entry has been cleared.
// Optional build macro GPR_BYPASS_EN: same-cycle forwarding of the write port
// (and the overflow write) onto the read ports.
module gpr_file_ext #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int OF_REG = 30,
    parameter int OF_VAL = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   rd_addr1,
    input  logic [ADDR_W-1:0]   rd_addr2,
    output logic [DATA_W-1:0]   rd_data1,
    output logic [DATA_W-1:0]   rd_data2,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                of,
    output logic                ready
);

    localparam int                DEPTH    = 2**ADDR_W;
    localparam int                NB       = DATA_W / 8;
    localparam logic [ADDR_W-1:0] OF_IDX   = ADDR_W'(OF_REG);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] OF_WORD  = DATA_W'(OF_VAL);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t              state, state_d;
    logic [ADDR_W-1:0]   clr_idx, clr_idx_d;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                run;
    logic                wr_hit;
    logic                of_hit;
    logic [1:0][ADDR_W-1:0] rd_sel;
    logic [1:0][DATA_W-1:0] rd_word;

    assign run    = (state == RUN);
    assign ready  = run;
    assign wr_hit = run && wr_en && (wr_addr != '0);
    assign of_hit = run && of;

    // Clear sequencer next state: walk every index once, then hand over to RUN.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch is inferred.
        state_d   = state;
        clr_idx_d = clr_idx;
        if (state == CLEAR) begin
            clr_idx_d = clr_idx + ADDR_W'(1);
            if (clr_idx == LAST_IDX) begin
                state_d = RUN;
            end
        end
    end

    // Sequencer state register; reset restarts the clear from index 0 in any state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_d;
            clr_idx <= clr_idx_d;
        end
    end

    // Storage: clear one entry per CLEAR cycle, otherwise byte writes then the overflow flag.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset branch; the sequencer clears it, and the reset edge leaves it untouched.
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clr_idx] <= '0;
            end else begin
                if (wr_hit) begin
                    for (int i = 0; i < NB; i++) begin
                        if (wr_be[i]) begin
                            mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                        end
                    end
                end
                // Last assignment wins, which gives the overflow flag priority over a same-edge write.
                if (of_hit) begin
                    mem[OF_IDX] <= OF_WORD;
                end
            end
        end
    end

    assign rd_sel = {rd_addr2, rd_addr1};

    // Read ports: zero while clearing and for address 0, otherwise the stored (or forwarded) word.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_word[p] = '0;
            if (run && (rd_sel[p] != '0)) begin
                rd_word[p] = mem[rd_sel[p]];
`ifdef GPR_BYPASS_EN
                if (wr_hit && (rd_sel[p] == wr_addr)) begin
                    for (int i = 0; i < NB; i++) begin
                        if (wr_be[i]) begin
                            rd_word[p][8*i +: 8] = wr_data[8*i +: 8];
                        end
                    end
                end
                if (of_hit && (rd_sel[p] == OF_IDX)) begin
                    rd_word[p] = OF_WORD;
                end
`else
                // Without forwarding a write shows up on the read ports the cycle after its edge.
`endif
            end
        end
    end

    assign rd_data1 = rd_word[0];
    assign rd_data2 = rd_word[1];

endmodule
